// File: rtl/breakout_pkg.sv
// ----------------------------------------------------------------------------
// breakout_pkg
//   Shared definitions for the breakout game blocks: screen size, default
//   brick-grid geometry, ball size, the collider FSM state type and a small
//   min helper used for penetration depth.
//   No ports.
// ----------------------------------------------------------------------------
package breakout_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    localparam int NUM_BRICKS = 16;
    localparam int BRICK_COLS = 8;
    localparam int BRICK_W    = 80;
    localparam int BRICK_H    = 20;
    localparam int BRICK_X0   = 0;
    localparam int BRICK_Y0   = 40;
    localparam int BALL_SIZE  = 8;
    localparam int COOLDOWN   = 4;

    // Ball coordinates are 10 bits; all geometry compares are done one bit
    // wider so that ball + size and brick edge + width never wrap.
    localparam int COORD_W    = 10;
    localparam int CMP_W      = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HIT  = 2'd2,
        ST_COOL = 2'd3
    } collider_state_t;

    function automatic logic [CMP_W-1:0] min_cmp(input logic [CMP_W-1:0] a,
                                                 input logic [CMP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/brick_collider_if.sv
// ----------------------------------------------------------------------------
// brick_collider_if
//   Bundles the collider's frame/ball/brick inputs and its kill/bounce
//   outputs.
//   master : ball controller / brick array side (drives tick, ball, alive)
//   slave  : brick_collider (drives kill, bounce_x/y, hit_idx, busy)
//   Optional macro BRICK_SCORE_EN adds score[15:0] (driven by the slave).
// ----------------------------------------------------------------------------
interface brick_collider_if
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS = breakout_pkg::NUM_BRICKS,
    localparam int IDX_W     = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) ();

    logic                  frame_tick;
    logic [COORD_W-1:0]    ball_x;
    logic [COORD_W-1:0]    ball_y;
    logic [NUM_BRICKS-1:0] brick_alive;
    logic [NUM_BRICKS-1:0] kill;
    logic                  bounce_x;
    logic                  bounce_y;
    logic [IDX_W-1:0]      hit_idx;
    logic                  busy;
`ifdef BRICK_SCORE_EN
    logic [15:0]           score;

    modport master (
        output frame_tick, ball_x, ball_y, brick_alive,
        input  kill, bounce_x, bounce_y, hit_idx, busy, score
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, brick_alive,
        output kill, bounce_x, bounce_y, hit_idx, busy, score
    );
`else
    modport master (
        output frame_tick, ball_x, ball_y, brick_alive,
        input  kill, bounce_x, bounce_y, hit_idx, busy
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, brick_alive,
        output kill, bounce_x, bounce_y, hit_idx, busy
    );
`endif

endinterface

// File: rtl/brick_geom.sv
// ----------------------------------------------------------------------------
// brick_geom
//   Combinational brick index -> top-left corner {x0, y0}. Shared with the
//   brick renderer so both agree on where each brick lives.
//   idx : brick index, row*BRICK_COLS + col
//   x0  : left edge   (CMP_W bits)
//   y0  : top edge    (CMP_W bits)
//   BRICK_COLS is a power of two, so the divide/modulo reduce to bit slicing.
// ----------------------------------------------------------------------------
module brick_geom
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS = breakout_pkg::NUM_BRICKS,
    parameter int BRICK_COLS = breakout_pkg::BRICK_COLS,
    parameter int BRICK_W    = breakout_pkg::BRICK_W,
    parameter int BRICK_H    = breakout_pkg::BRICK_H,
    parameter int BRICK_X0   = breakout_pkg::BRICK_X0,
    parameter int BRICK_Y0   = breakout_pkg::BRICK_Y0,
    localparam int IDX_W     = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
    input  logic [IDX_W-1:0] idx,
    output logic [CMP_W-1:0] x0,
    output logic [CMP_W-1:0] y0
);

    assign x0 = CMP_W'(BRICK_X0 + (int'(idx) % BRICK_COLS) * BRICK_W);
    assign y0 = CMP_W'(BRICK_Y0 + (int'(idx) / BRICK_COLS) * BRICK_H);

endmodule

// File: rtl/brick_collider.sv
// ----------------------------------------------------------------------------
// brick_collider
//   Once per frame, walks the brick grid one brick per cycle against the
//   latched ball box. The first live brick overlapped gets a one-cycle kill
//   pulse, and the ball controller gets a one-cycle bounce on the axis of
//   shallower penetration. After a hit, COOLDOWN frame ticks are ignored.
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high
//     bus    : brick_collider_if.slave (frame_tick, ball_x/y, brick_alive in;
//              kill, bounce_x/y, hit_idx, busy [, score] out)
//   Optional macro BRICK_SCORE_EN: saturating 16-bit hit counter on bus.score.
// ----------------------------------------------------------------------------
module brick_collider
    import breakout_pkg::*;
#(
    parameter int NUM_BRICKS = breakout_pkg::NUM_BRICKS,
    parameter int BRICK_COLS = breakout_pkg::BRICK_COLS,
    parameter int BRICK_W    = breakout_pkg::BRICK_W,
    parameter int BRICK_H    = breakout_pkg::BRICK_H,
    parameter int BRICK_X0   = breakout_pkg::BRICK_X0,
    parameter int BRICK_Y0   = breakout_pkg::BRICK_Y0,
    parameter int BALL_SIZE  = breakout_pkg::BALL_SIZE,
    parameter int COOLDOWN   = breakout_pkg::COOLDOWN
) (
    input logic             clk,
    input logic             reset,
    brick_collider_if.slave bus
);

    localparam int IDX_W = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    collider_state_t       state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [COORD_W-1:0]    bx_q, by_q;

    logic [NUM_BRICKS-1:0] kill_q, kill_d;
    logic                  bounce_x_q, bounce_x_d;
    logic                  bounce_y_q, bounce_y_d;
    logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
    logic                  busy_q, busy_d;

    // ---------------- geometry of the brick under scan ----------------
    logic [CMP_W-1:0] x0, y0;

    brick_geom #(
        .NUM_BRICKS (NUM_BRICKS),
        .BRICK_COLS (BRICK_COLS),
        .BRICK_W    (BRICK_W),
        .BRICK_H    (BRICK_H),
        .BRICK_X0   (BRICK_X0),
        .BRICK_Y0   (BRICK_Y0)
    ) u_geom (
        .idx (idx_q),
        .x0  (x0),
        .y0  (y0)
    );

    logic [CMP_W-1:0] ball_l, ball_r, ball_t, ball_b;
    logic [CMP_W-1:0] brick_r, brick_b;
    logic [CMP_W-1:0] dx, dy;
    logic             overlap, hit;

    assign ball_l  = {1'b0, bx_q};
    assign ball_t  = {1'b0, by_q};
    assign ball_r  = ball_l + CMP_W'(BALL_SIZE);
    assign ball_b  = ball_t + CMP_W'(BALL_SIZE);
    assign brick_r = x0 + CMP_W'(BRICK_W);
    assign brick_b = y0 + CMP_W'(BRICK_H);

    // Half-open intervals: touching edges do not count as a hit.
    assign overlap = (ball_l < brick_r) && (x0 < ball_r) &&
                     (ball_t < brick_b) && (y0 < ball_b);
    assign hit     = bus.brick_alive[idx_q] && overlap;

    // Only meaningful when overlap holds, so both differences are positive.
    assign dx = min_cmp(ball_r - x0, brick_r - ball_l);
    assign dy = min_cmp(ball_b - y0, brick_b - ball_t);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.frame_tick) begin
                bx_q <= bus.ball_x;
                by_q <= bus.ball_y;
            end
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    state_d = ST_HIT;
                end else if (idx_q == IDX_W'(NUM_BRICKS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_HIT: begin
                cnt_d   = '0;
                state_d = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
            end
            ST_COOL: begin
                // The tick that ends cooldown is consumed; scanning resumes
                // on the following tick.
                if (bus.frame_tick) begin
                    if (cnt_q == CNT_W'(COOLDOWN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----
    always_comb begin
        kill_d     = '0;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        hit_idx_d  = hit_idx_q;
        busy_d     = (state_d == ST_SCAN) || (state_d == ST_HIT);
        if (state_q == ST_SCAN && hit) begin
            kill_d[idx_q] = 1'b1;
            hit_idx_d     = idx_q;
            // Tie goes to the y axis.
            bounce_x_d    = (dx < dy);
            bounce_y_d    = !(dx < dy);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_q     <= '0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            hit_idx_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            kill_q     <= kill_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
            hit_idx_q  <= hit_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.kill     = kill_q;
    assign bus.bounce_x = bounce_x_q;
    assign bus.bounce_y = bounce_y_q;
    assign bus.hit_idx  = hit_idx_q;
    assign bus.busy     = busy_q;

`ifdef BRICK_SCORE_EN
    logic [15:0] score_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else if (state_q == ST_HIT && score_q != 16'hFFFF) begin
            score_q <= score_q + 16'd1;
        end
    end

    assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_brick_collider.sv
// ----------------------------------------------------------------------------
// tb_brick_collider
//   Self-checking bench for brick_collider: directed frames plus random
//   frames, compared cycle by cycle against a geometric reference model.
//   Compile with +define+BRICK_SCORE_EN to also check the score counter.
// ----------------------------------------------------------------------------
module tb_brick_collider;
    import breakout_pkg::*;

    localparam int NB     = breakout_pkg::NUM_BRICKS;
    localparam int WINDOW = NB + 2;   // cycles observed after each tick

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    // Reference-model state
    int cool_left = 0;
    int last_hit  = 0;
    int score_m   = 0;

    brick_collider_if bus_if ();

    brick_collider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // First live brick the ball box overlaps, straight from the geometry.
    task automatic model_frame(input int bx, input int by, input logic [NB-1:0] alive,
                               output bit hit, output int k, output bit axis_x);
        hit    = 1'b0;
        k      = 0;
        axis_x = 1'b0;
        for (int i = 0; i < NB; i++) begin
            int x0, y0, dx, dy;
            x0 = BRICK_X0 + (i % BRICK_COLS) * BRICK_W;
            y0 = BRICK_Y0 + (i / BRICK_COLS) * BRICK_H;
            if (!hit && alive[i] &&
                bx < x0 + BRICK_W && x0 < bx + BALL_SIZE &&
                by < y0 + BRICK_H && y0 < by + BALL_SIZE) begin
                dx = (bx + BALL_SIZE - x0 < x0 + BRICK_W - bx) ? bx + BALL_SIZE - x0 : x0 + BRICK_W - bx;
                dy = (by + BALL_SIZE - y0 < y0 + BRICK_H - by) ? by + BALL_SIZE - y0 : y0 + BRICK_H - by;
                hit    = 1'b1;
                k      = i;
                axis_x = (dx < dy);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".kill"},     32'(bus_if.kill),     32'd0);
        check({tag, ".bounce_x"}, 32'(bus_if.bounce_x), 32'd0);
        check({tag, ".bounce_y"}, 32'(bus_if.bounce_y), 32'd0);
        check({tag, ".busy"},     32'(bus_if.busy),     32'd0);
        check({tag, ".hit_idx"},  32'(bus_if.hit_idx),  32'd0);
`ifdef BRICK_SCORE_EN
        check({tag, ".score"},    32'(bus_if.score),    32'd0);
`endif
    endtask

    task automatic model_reset();
        cool_left = 0;
        last_hit  = 0;
        score_m   = 0;
    endtask

    // Called at posedge+#1. Pulses frame_tick for one cycle (cycle T) and
    // then checks the following WINDOW cycles against the model.
    task automatic run_frame(input int bx, input int by, input logic [NB-1:0] alive);
        bit hit, axis_x, active;
        int k;
        bus_if.ball_x      = 10'(bx);
        bus_if.ball_y      = 10'(by);
        bus_if.brick_alive = alive;
        bus_if.frame_tick  = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_tick = 1'b0;
        if (cool_left > 0) begin
            cool_left--;
            active = 1'b0;
            hit    = 1'b0;
            k      = 0;
            axis_x = 1'b0;
        end else begin
            active = 1'b1;
            model_frame(bx, by, alive, hit, k, axis_x);
        end
        for (int c = 1; c <= WINDOW; c++) begin
            bit pulse, exp_busy;
            pulse    = hit && (c == k + 2);
            exp_busy = active && (hit ? (c <= k + 2) : (c <= NB));
            check("kill",     32'(bus_if.kill),     pulse ? (32'd1 << k) : 32'd0);
            check("bounce_x", 32'(bus_if.bounce_x), 32'(pulse && axis_x));
            check("bounce_y", 32'(bus_if.bounce_y), 32'(pulse && !axis_x));
            check("busy",     32'(bus_if.busy),     32'(exp_busy));
            @(posedge clk);
            #1;
        end
        if (hit) begin
            last_hit  = k;
            cool_left = COOLDOWN;
            if (score_m < 16'hFFFF) score_m++;
        end
        check("hit_idx", 32'(bus_if.hit_idx), 32'(last_hit));
`ifdef BRICK_SCORE_EN
        check("score", 32'(bus_if.score), 32'(score_m));
`endif
    endtask

    initial begin
        logic [NB-1:0] all_alive;
        all_alive          = '1;
        reset              = 1'b1;
        bus_if.frame_tick  = 1'b0;
        bus_if.ball_x      = '0;
        bus_if.ball_y      = '0;
        bus_if.brick_alive = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        model_reset();

        // Ball on brick 0, y penetration shallower.
        run_frame(10, 50, all_alive);
        // Four ignored ticks of cooldown.
        for (int i = 0; i < COOLDOWN; i++) run_frame(10, 50, all_alive);
        // Brick 0 dead: nothing hit, full scan.
        run_frame(10, 50, all_alive & ~NB'(1));
        // Straddling bricks 0/1: lowest index wins, x penetration shallower.
        run_frame(76, 50, all_alive);
        // Cooldown with ball on brick 1, then the fifth tick kills brick 1.
        for (int i = 0; i < COOLDOWN; i++) run_frame(100, 50, all_alive);
        run_frame(100, 50, all_alive);
        for (int i = 0; i < COOLDOWN; i++) run_frame(100, 50, all_alive);

        // Reset while scanning index 5.
        bus_if.ball_x      = 10'd10;
        bus_if.ball_y      = 10'd50;
        bus_if.brick_alive = '0;
        bus_if.frame_tick  = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset.busy", 32'(bus_if.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("mid_scan_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        run_frame(10, 50, all_alive);
        for (int i = 0; i < COOLDOWN; i++) run_frame(10, 50, all_alive);

        // Reset during the HIT cycle of brick 1: kill must drop at once.
        bus_if.ball_x      = 10'd100;
        bus_if.ball_y      = 10'd50;
        bus_if.brick_alive = all_alive;
        bus_if.frame_tick  = 1'b1;
        @(posedge clk);
        #1 bus_if.frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset.kill", 32'(bus_if.kill), 32'h2);
        #2 reset = 1'b1;
        #1;
        check_all_zero("hit_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Random frames over the brick band and around it.
        for (int n = 0; n < 80; n++) begin
            int bx, by;
            logic [NB-1:0] alive;
            bx    = int'($urandom_range(0, 700));
            by    = int'($urandom_range(20, 110));
            alive = NB'($urandom | $urandom);
            if (n % 5 == 0) alive = NB'($urandom & $urandom);
            run_frame(bx, by, alive);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
